exception_unit: RTL and testbench
=================================

# exception_unit

Sequential exception/interrupt handling stage that consumes the controller's `Exc`, `ERet` and `EStatus` outputs and feeds `ExtIRQ`/`ExcAck` back into it. It latches external interrupt requests, saves the faulting or interrupted PC and cause into `ELR`/`ESR`, and selects the next-PC source (sequential, exception vector or return). It enforces single-level (non-nested) handling and locks the core on a double fault. It sits between the controller and the fetch-stage PC mux of the LEGv8 datapath.

## Interface
- `N`, 64, PC/ELR width
- `EXC_VECTOR`, 64'hD8, handler entry address driven on `excPC`
- `clk`  in  1  core clock, all state updates on rising edge
- `reset`  in  1  synchronous, active-low; state cleared on a rising edge with `reset==0`
- `irq_req`  in  1  raw external interrupt request line (level, synchronous to `clk`)
- `Exc`  in  1  exception request from controller (ExtIRQ or NotAnInstr)
- `ERet`  in  1  ERET instruction decoded
- `EStatus`  in  4  cause code from controller
- `ExtlAck`  in  1  controller's interrupt acknowledge
- `PC`  in  N  address of instruction currently executing
- `ExtIRQ`  out  1  masked pending interrupt to controller
- `ExcAck`  out  1  exception accepted this cycle
- `PCSel`  out  2  00 PC+4 / branch, 01 `excPC`, 10 `ELR`, 11 hold `PC`
- `excPC`  out  N  constant `EXC_VECTOR`
- `ELR`  out  N  saved return address
- `ESR`  out  4  saved cause
- `in_handler`  out  1  state is HANDLER
- `locked`  out  1  state is LOCKED

## Operation
- FSM states: IDLE, HANDLER, LOCKED.
- IDLE & `Exc` → HANDLER; `ELR<=PC`, `ESR<=EStatus`; `ExcAck=1`, `PCSel=01` in the same cycle (combinational).
- IDLE & `ERet` & !`Exc` → stay IDLE; `PCSel=00` (ERET outside handler is a NOP).
- HANDLER & `ERet` & !`Exc` → IDLE; `PCSel=10`.
- HANDLER & `Exc` → LOCKED (double fault); `ELR`/`ESR` unchanged; `ExcAck=0`; `PCSel=11`. `Exc` has priority over `ERet`.
- LOCKED: absorbing until reset; `PCSel=11`; `ExtIRQ=0`; all inputs ignored.
- IRQ latch: `irq_q<=irq_req` each cycle; rising edge `rise=irq_req & !irq_q`. `pending<=(pending & !ExtlAck) | rise` (a rise in the same cycle as an ack keeps `pending` set).
- `ExtIRQ = pending & (state==IDLE)`: interrupts are masked while in HANDLER and LOCKED, and `pending` is kept for delivery after ERET.
- `ExcAck` is asserted only in IDLE. The controller's `ExtlAck = ExcAck & ExtIRQ` therefore clears `pending` exactly when the IRQ is taken. A NotAnInstr exception leaves `pending` intact.
- `EStatus` is stored verbatim; no decoding in this block.

## Timing
- Reset values: state IDLE, `ELR=0`, `ESR=0`, `pending=0`, `irq_q=0`. Outputs: `ExtIRQ=0`, `ExcAck=0`, `PCSel=00`, `in_handler=0`, `locked=0`.
- `PCSel`, `ExcAck` and `ExtIRQ` are combinational from current state and inputs, with zero-cycle redirect. `ELR`, `ESR`, state and `pending` update on the next edge.
- IRQ latency: `irq_req` rise at edge k → `pending` at k+1 → `ExtIRQ` visible in cycle k+1 if IDLE.
- Reset asserted while in HANDLER or LOCKED: the next edge forces all reset values. Any `Exc` present in that cycle is discarded.
- `irq_req` held high produces one pending event only. A new event requires a low then a high.

## Structure
- Package `exc_pkg`: `exc_state_t` enum {IDLE, HANDLER, LOCKED}; `PCSEL_SEQ/VEC/ELR/HOLD` 2-bit constants; EStatus cause codes `ES_EXTIRQ=4'b0001`, `ES_BADOP=4'b0010`.
- One sub-module `irq_latch` (edge detect + pending set/clear). The FSM and ELR/ESR registers live in the top.

## Test plan
- Reset low 2 cycles with `irq_req=1` → all outputs at reset values. Release reset → `pending` set one cycle later and `ExtIRQ=1`.
- IDLE, `PC=64'h40`, `Exc=1`, `EStatus=4'b0010` → same cycle `ExcAck=1`, `PCSel=01`. Next cycle `ELR=64'h40`, `ESR=2`, `in_handler=1`, and a prior `pending` is still 1.
- IRQ pulse while in HANDLER → `ExtIRQ=0`. `ERet=1` → `PCSel=10`. Next cycle IDLE and `ExtIRQ=1`. With `Exc`/`ExtlAck`: `pending` clears, `ESR=1`.
- HANDLER with `Exc=1` and `ERet=1` simultaneously → LOCKED, `locked=1`, `PCSel=11`, `ELR`/`ESR` unchanged. A later `ERet` has no effect. `reset=0` → IDLE.
- `ERet=1` in IDLE → `PCSel=00`, state stays IDLE. `irq_req` held high 10 cycles with ack at cycle 3 → exactly one `ExtIRQ` assertion.

Source files
------------

// File: rtl/exc_pkg.sv
// Shared types and constants for the exception unit.
// Defines the handler FSM states, next-PC select codes and cause codes.
package exc_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HANDLER = 2'd1,
        LOCKED  = 2'd2
    } exc_state_t;

    localparam logic [1:0] PCSEL_SEQ  = 2'b00;
    localparam logic [1:0] PCSEL_VEC  = 2'b01;
    localparam logic [1:0] PCSEL_ELR  = 2'b10;
    localparam logic [1:0] PCSEL_HOLD = 2'b11;

    localparam logic [3:0] ES_EXTIRQ = 4'b0001;
    localparam logic [3:0] ES_BADOP  = 4'b0010;

endpackage

// File: rtl/exception_unit_irq_latch.sv
// Rising-edge detector and pending flag for the external interrupt line.
// Ports: clk, reset (sync, active-low), irq_req, ack in; pending out.
module irq_latch (
    input  logic clk,
    input  logic reset,
    input  logic irq_req,
    input  logic ack,
    output logic pending
);

    logic irq_q, irq_d;
    logic pending_q, pending_d;
    logic rise;

    always_comb begin
        rise      = irq_req & ~irq_q;
        irq_d     = irq_req;
        // A new edge wins over an ack in the same cycle.
        pending_d = (pending_q & ~ack) | rise;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            irq_q     <= 1'b0;
            pending_q <= 1'b0;
        end else begin
            irq_q     <= irq_d;
            pending_q <= pending_d;
        end
    end

    assign pending = pending_q;

endmodule

// File: rtl/exception_unit.sv
// Single-level exception/interrupt stage: saves ELR/ESR, selects next PC.
// Ports: irq_req/Exc/ERet/EStatus/ExtlAck/PC in; ExtIRQ/ExcAck/PCSel/excPC/ELR/ESR/status out.
module exception_unit
    import exc_pkg::*;
#(
    parameter int             N          = 64,
    parameter logic [N-1:0]   EXC_VECTOR = 64'hD8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         irq_req,
    input  logic         Exc,
    input  logic         ERet,
    input  logic [3:0]   EStatus,
    input  logic         ExtlAck,
    input  logic [N-1:0] PC,
    output logic         ExtIRQ,
    output logic         ExcAck,
    output logic [1:0]   PCSel,
    output logic [N-1:0] excPC,
    output logic [N-1:0] ELR,
    output logic [3:0]   ESR,
    output logic         in_handler,
    output logic         locked
);

    exc_state_t   state_q, state_d;
    logic [N-1:0] elr_q, elr_d;
    logic [3:0]   esr_q, esr_d;
    logic         pending;

    irq_latch u_irq_latch (
        .clk     (clk),
        .reset   (reset),
        .irq_req (irq_req),
        .ack     (ExtlAck),
        .pending (pending)
    );

    always_comb begin
        state_d = state_q;
        elr_d   = elr_q;
        esr_d   = esr_q;
        ExcAck  = 1'b0;
        PCSel   = PCSEL_SEQ;
        unique case (state_q)
            IDLE: begin
                // ERET here is a NOP.
                if (Exc) begin
                    state_d = HANDLER;
                    elr_d   = PC;
                    esr_d   = EStatus;
                    ExcAck  = 1'b1;
                    PCSel   = PCSEL_VEC;
                end
            end
            HANDLER: begin
                // A fault inside the handler is fatal and beats ERET.
                if (Exc) begin
                    state_d = LOCKED;
                    PCSel   = PCSEL_HOLD;
                end else if (ERet) begin
                    state_d = IDLE;
                    PCSel   = PCSEL_ELR;
                end
            end
            LOCKED: begin
                PCSel = PCSEL_HOLD;
            end
            default: begin
                state_d = LOCKED;
                PCSel   = PCSEL_HOLD;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            elr_q   <= '0;
            esr_q   <= '0;
        end else begin
            state_q <= state_d;
            elr_q   <= elr_d;
            esr_q   <= esr_d;
        end
    end

    // Pending IRQs are held, not dropped, while masked.
    assign ExtIRQ     = pending & (state_q == IDLE);
    assign excPC      = EXC_VECTOR;
    assign ELR        = elr_q;
    assign ESR        = esr_q;
    assign in_handler = (state_q == HANDLER);
    assign locked     = (state_q == LOCKED);

endmodule

// File: tb/tb_exception_unit.sv
// Self-checking bench for exception_unit: directed table, IRQ hold test,
// and randomized stimulus against a behavioural model.
module tb_exception_unit;
    import exc_pkg::*;

    logic        clk = 1'b0;
    logic        reset, irq_req, Exc, ERet, ExtlAck;
    logic [3:0]  EStatus;
    logic [63:0] PC;
    logic        ExtIRQ, ExcAck, in_handler, locked;
    logic [1:0]  PCSel;
    logic [63:0] excPC, ELR;
    logic [3:0]  ESR;

    int n_pass = 0;
    int n_total = 0;

    exception_unit dut (
        .clk(clk), .reset(reset), .irq_req(irq_req), .Exc(Exc),
        .ERet(ERet), .EStatus(EStatus), .ExtlAck(ExtlAck), .PC(PC),
        .ExtIRQ(ExtIRQ), .ExcAck(ExcAck), .PCSel(PCSel), .excPC(excPC),
        .ELR(ELR), .ESR(ESR), .in_handler(in_handler), .locked(locked)
    );

    always #5 clk = ~clk;

    // Behavioural model: handler nesting depth 0/1 plus a fatal flag.
    bit          m_in_h, m_lock, m_pend, m_prev;
    logic [63:0] m_elr;
    logic [3:0]  m_esr;

    typedef struct {
        bit          rst, irq, exc, eret;
        logic [3:0]  es;
        bit          eack;
        logic [63:0] pc;
        bit          x_irq, x_ack;
        logic [1:0]  x_sel;
        logic [63:0] x_elr;
        logic [3:0]  x_esr;
        bit          x_inh, x_lk;
    } vec_t;

    vec_t tbl[19];

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t",
                      name, act, exp, $time);
    endtask

    task automatic drive(bit r, bit i, bit e, bit er,
                         logic [3:0] es, bit ak, logic [63:0] pc);
        @(negedge clk);
        reset = r; irq_req = i; Exc = e; ERet = er;
        EStatus = es; ExtlAck = ak; PC = pc;
        #2;
    endtask

    // Advance one edge and update the model from the applied inputs.
    task automatic tick();
        bit nxt_pend;
        @(posedge clk);
        if (!reset) begin
            m_in_h = 0; m_lock = 0; m_pend = 0; m_prev = 0;
            m_elr = '0; m_esr = '0;
        end else begin
            nxt_pend = (m_pend && !ExtlAck) || (irq_req && !m_prev);
            m_prev = irq_req;
            m_pend = nxt_pend;
            if (m_lock) begin
            end else if (m_in_h) begin
                if (Exc) begin m_lock = 1; m_in_h = 0; end
                else if (ERet) m_in_h = 0;
            end else if (Exc) begin
                m_in_h = 1; m_elr = PC; m_esr = EStatus;
            end
        end
    endtask

    function automatic logic [1:0] model_sel();
        if (m_lock) return 2'd3;
        if (m_in_h) return Exc ? 2'd3 : (ERet ? 2'd2 : 2'd0);
        return Exc ? 2'd1 : 2'd0;
    endfunction

    task automatic check_model();
        bit idle;
        idle = !m_in_h && !m_lock;
        chk("rnd_extirq", ExtIRQ, m_pend && idle);
        chk("rnd_excack", ExcAck, Exc && idle);
        chk("rnd_pcsel", PCSel, model_sel());
        chk("rnd_elr", ELR, m_elr);
        chk("rnd_esr", ESR, m_esr);
        chk("rnd_inh", in_handler, m_in_h);
        chk("rnd_lock", locked, m_lock);
    endtask

    initial begin
        int rises;
        bit last_irq;
        bit r, i, e, er, ak;
        logic [3:0] es;

        //          rst irq exc eret es ack pc      xi xa xs elr    esr inh lk
        tbl[0]  = '{0, 1, 0, 0, 0, 0, 64'h0,   0, 0, 0, 64'h0,   0, 0, 0};
        tbl[1]  = '{1, 1, 0, 0, 0, 0, 64'h0,   0, 0, 0, 64'h0,   0, 0, 0};
        tbl[2]  = '{1, 1, 0, 0, 0, 0, 64'h0,   1, 0, 0, 64'h0,   0, 0, 0};
        tbl[3]  = '{1, 1, 1, 0, 2, 0, 64'h40,  1, 1, 1, 64'h0,   0, 0, 0};
        tbl[4]  = '{1, 0, 0, 0, 0, 0, 64'h0,   0, 0, 0, 64'h40,  2, 1, 0};
        tbl[5]  = '{1, 1, 0, 0, 0, 0, 64'h0,   0, 0, 0, 64'h40,  2, 1, 0};
        tbl[6]  = '{1, 0, 0, 1, 0, 0, 64'h0,   0, 0, 2, 64'h40,  2, 1, 0};
        tbl[7]  = '{1, 0, 1, 0, 1, 1, 64'h80,  1, 1, 1, 64'h40,  2, 0, 0};
        tbl[8]  = '{1, 0, 0, 0, 0, 0, 64'h0,   0, 0, 0, 64'h80,  1, 1, 0};
        tbl[9]  = '{1, 0, 0, 1, 0, 0, 64'h0,   0, 0, 2, 64'h80,  1, 1, 0};
        tbl[10] = '{1, 0, 0, 0, 0, 0, 64'h0,   0, 0, 0, 64'h80,  1, 0, 0};
        tbl[11] = '{1, 0, 1, 0, 2, 0, 64'hC0,  0, 1, 1, 64'h80,  1, 0, 0};
        tbl[12] = '{1, 0, 1, 1, 1, 0, 64'h100, 0, 0, 3, 64'hC0,  2, 1, 0};
        tbl[13] = '{1, 0, 0, 1, 0, 0, 64'h0,   0, 0, 3, 64'hC0,  2, 0, 1};
        tbl[14] = '{1, 1, 1, 0, 3, 0, 64'h200, 0, 0, 3, 64'hC0,  2, 0, 1};
        tbl[15] = '{0, 1, 1, 0, 0, 0, 64'h0,   0, 0, 3, 64'hC0,  2, 0, 1};
        tbl[16] = '{1, 1, 0, 0, 0, 0, 64'h0,   0, 0, 0, 64'h0,   0, 0, 0};
        tbl[17] = '{1, 1, 0, 1, 0, 0, 64'h0,   1, 0, 0, 64'h0,   0, 0, 0};
        tbl[18] = '{1, 0, 0, 0, 0, 0, 64'h0,   1, 0, 0, 64'h0,   0, 0, 0};

        drive(0, 1, 0, 0, 0, 0, 0);
        tick();
        chk("excpc", excPC, 64'hD8);

        for (int k = 0; k < 19; k++) begin
            drive(tbl[k].rst, tbl[k].irq, tbl[k].exc, tbl[k].eret,
                  tbl[k].es, tbl[k].eack, tbl[k].pc);
            chk($sformatf("t%0d_extirq", k), ExtIRQ, tbl[k].x_irq);
            chk($sformatf("t%0d_excack", k), ExcAck, tbl[k].x_ack);
            chk($sformatf("t%0d_pcsel", k), PCSel, tbl[k].x_sel);
            chk($sformatf("t%0d_elr", k), ELR, tbl[k].x_elr);
            chk($sformatf("t%0d_esr", k), ESR, tbl[k].x_esr);
            chk($sformatf("t%0d_inh", k), in_handler, tbl[k].x_inh);
            chk($sformatf("t%0d_lock", k), locked, tbl[k].x_lk);
            tick();
        end

        // irq_req held high for 10 cycles, ack while asserted at cycle 3.
        drive(0, 0, 0, 0, 0, 0, 0);
        tick();
        rises = 0;
        last_irq = 0;
        for (int c = 0; c < 10; c++) begin
            drive(1, 1, 0, 0, 0, (c == 3), 0);
            if (ExtIRQ && !last_irq) rises++;
            last_irq = ExtIRQ;
            tick();
        end
        chk("hold_one_event", rises, 1);
        drive(1, 1, 0, 0, 0, 0, 0);
        chk("hold_cleared", ExtIRQ, 0);
        tick();

        // Randomized run against the model.
        i = 0;
        for (int c = 0; c < 600; c++) begin
            r  = ($urandom_range(0, 39) != 0);
            if ($urandom_range(0, 3) == 0) i = ~i;
            e  = ($urandom_range(0, 5) == 0);
            er = ($urandom_range(0, 3) == 0);
            ak = ($urandom_range(0, 2) == 0);
            es = $urandom_range(0, 1) ? ES_EXTIRQ : ES_BADOP;
            if ($urandom_range(0, 3) == 0) es = 4'($urandom);
            drive(r, i, e, er, es, ak,
                  {$urandom, $urandom});
            check_model();
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
